alu_4: RTL and testbench

//   4-bit ALU: six bitwise ops plus add/subtract, with carry, negative, zero
//   and overflow flags. Datapath is purely combinational (same-cycle result).
//   A registered copy of result/flags is provided for downstream status logic.

---
 rtl/alu_4.sv | 74 +++++++
 tb/tb_alu_4.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_4.sv
// 4-bit ALU with combinational result/flags and a one-cycle registered copy.
// Add and subtract share one adder; subtract feeds ~b with carry-in from op[0].
module alu_4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v,
  output logic [3:0] result_q,
  output logic [3:0] flags_q
);

  typedef enum logic [2:0] {
    OP_NOT_A = 3'b000,
    OP_NOT_B = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ADD   = 3'b110,
    OP_SUB   = 3'b111
  } op_e;

  op_e        w_op;
  logic [3:0] w_b_eff;
  logic [4:0] w_sum;
  logic       w_arith_v;

  assign w_op    = op_e'(op);
  assign w_b_eff = op[0] ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {4'b0000, op[0]};

  // With b already inverted for subtract, one overflow rule covers both ops.
  assign w_arith_v = (a[3] == w_b_eff[3]) && (w_sum[3] != a[3]);

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (w_op)
      OP_NOT_A: result = ~a;
      OP_NOT_B: result = ~b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_XNOR:  result = ~(a ^ b);
      OP_ADD, OP_SUB: begin
        result = w_sum[3:0];
        c      = w_sum[4];
        v      = w_arith_v;
      end
      default: result = '0;
    endcase
  end

  assign n = result[3];
  assign z = (result == 4'b0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result;
      flags_q  <= {c, n, z, v};
    end
  end

endmodule

// File: tb/tb_alu_4.sv
// Directed and exhaustive checks of alu_4 against hand values and an
// integer-arithmetic reference model; comb outputs at negedge, registered after edge.
module tb_alu_4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a, b;
  logic [2:0] op;
  logic [3:0] result, result_q, flags_q;
  logic       c, n, z, v;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  alu_4 dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (result),
    .c        (c),
    .n        (n),
    .z        (z),
    .v        (v),
    .result_q (result_q),
    .flags_q  (flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Reference: {result, c, n, z, v}, computed with plain integer arithmetic.
  function automatic logic [7:0] ref_alu(input logic [2:0] f_op, input logic [3:0] f_a,
                                         input logic [3:0] f_b);
    int ua, ub, sa, sb, s, t;
    logic [3:0] r;
    logic       rc, rv;
    ua = int'(f_a);
    ub = int'(f_b);
    sa = f_a[3] ? ua - 16 : ua;
    sb = f_b[3] ? ub - 16 : ub;
    rc = 1'b0;
    rv = 1'b0;
    case (f_op)
      3'd0: r = ~f_a;
      3'd1: r = ~f_b;
      3'd2: r = f_a & f_b;
      3'd3: r = f_a | f_b;
      3'd4: r = f_a ^ f_b;
      3'd5: r = ~(f_a ^ f_b);
      3'd6: begin
        t  = ua + ub;
        r  = t[3:0];
        rc = (t > 15);
        s  = sa + sb;
        rv = (s > 7) || (s < -8);
      end
      default: begin
        t  = ua - ub;
        r  = t[3:0];
        rc = (ua >= ub);
        s  = sa - sb;
        rv = (s > 7) || (s < -8);
      end
    endcase
    return {r, rc, r[3], (r == 4'd0), rv};
  endfunction

  task automatic apply(input logic [2:0] t_op, input logic [3:0] t_a, input logic [3:0] t_b);
    @(posedge clk);
    #1;
    op = t_op;
    a  = t_a;
    b  = t_b;
    @(negedge clk);
  endtask

  logic [7:0] exp_prev;
  logic       have_prev;

  initial begin
    reset = 1'b1;
    op = 3'b110;
    a  = 4'b0111;
    b  = 4'b0001;

    // Reset: registered outputs clear, comb outputs still track inputs.
    @(posedge clk);
    @(negedge clk);
    chk("reset_result_q", {4'b0, result_q}, 8'b0000_0000);
    chk("reset_flags_q",  {4'b0, flags_q},  8'b0000_0000);
    chk("reset_comb",     {result, c, n, z, v}, 8'b1000_0101);

    // Release with the pos-overflow vector applied; next edge captures it.
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_result_q", {4'b0, result_q}, 8'b0000_1000);
    chk("rel_flags_q",  {4'b0, flags_q},  8'b0000_0101);

    // Directed vectors: {result,c,n,z,v}.
    apply(3'b110, 4'b0111, 4'b0001); chk("add_pos_ovf", {result, c, n, z, v}, 8'b1000_0101);
    apply(3'b110, 4'b1111, 4'b0001); chk("add_wrap",    {result, c, n, z, v}, 8'b0000_1010);
    apply(3'b111, 4'b0011, 4'b0101); chk("sub_borrow",  {result, c, n, z, v}, 8'b1110_0100);
    apply(3'b111, 4'b1000, 4'b0001); chk("sub_neg_ovf", {result, c, n, z, v}, 8'b0111_1001);
    apply(3'b010, 4'b1100, 4'b1010); chk("and",         {result, c, n, z, v}, 8'b1000_0100);
    apply(3'b000, 4'b1111, 4'b0110); chk("not_a_zero",  {result, c, n, z, v}, 8'b0000_0010);
    apply(3'b111, 4'b0101, 4'b0101); chk("sub_equal",   {result, c, n, z, v}, 8'b0000_1010);
    apply(3'b101, 4'b1010, 4'b0101); chk("xnor",        {result, c, n, z, v}, 8'b0000_0010);

    // Reset asserted mid-stream: register clears, comb keeps following inputs.
    @(posedge clk);
    #1;
    reset = 1'b1;
    op = 3'b011;
    a  = 4'b0100;
    b  = 4'b0010;
    @(negedge clk);
    chk("mid_reset_comb", {result, c, n, z, v}, 8'b0110_0000);
    @(posedge clk);
    #1;
    chk("mid_reset_q", {result_q, flags_q}, 8'b0000_0000);
    reset = 1'b0;

    // Exhaustive sweep; registered copy checked one edge after each vector.
    have_prev = 1'b0;
    exp_prev  = '0;
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] ab;
        logic [7:0] exp_now;
        ab = 8'(i);
        @(posedge clk);
        #1;
        if (have_prev)
          chk("sweep_q", {result_q, flags_q[3:0]}, {exp_prev[7:4], exp_prev[3:0]});
        op = 3'(o);
        a  = ab[7:4];
        b  = ab[3:0];
        exp_now = ref_alu(3'(o), ab[7:4], ab[3:0]);
        @(negedge clk);
        chk("sweep_comb", {result, c, n, z, v}, exp_now);
        exp_prev  = exp_now;
        have_prev = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("sweep_q_last", {result_q, flags_q}, exp_prev);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
